// File: rtl/adc_serial_capture_if.sv
// Signal bundle between the serial ADC capture block, the ADC pins and the downstream filter.
// The master side is the capture block; the slave side is the ADC/consumer environment.
interface adc_serial_capture_if;
  localparam int unsigned DATA_W = 12;

  logic              en;
  logic              adc_sdata;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    input  en, adc_sdata,
    output adc_cs_n, adc_sclk, dout, dout_valid, frame_err, busy
  );

  modport slave (
    output en, adc_sdata,
    input  adc_cs_n, adc_sclk, dout, dout_valid, frame_err, busy
  );
endinterface

// File: rtl/adc_serial_capture.sv
// Periodic 16-bit serial ADC frame capture with leading-zero frame check
// and offset-binary / two's-complement conversion to a 12-bit signed sample.
module adc_serial_capture #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 100,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  adc_serial_capture_if.master  bus
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned PER_W   = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_LO = 3'd2,
    SCLK_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                start;
  logic                div_last;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   conv;

  assign start    = bus.en && (per_cnt_q == '0) && (state_q == IDLE);
  assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign raw      = shreg_q[DATA_W-1:0];
  assign conv     = OFFSET_BINARY ? {~raw[DATA_W-1], raw[DATA_W-2:0]} : raw;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; pin and status outputs are decoded from the next state
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (!bus.en || (per_cnt_q == PER_W'(SAMPLE_PERIOD - 1))) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = PER_W'(per_cnt_q + PER_W'(1));
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d   = SCLK_LO;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + DIV_W'(1));
        end
      end
      SCLK_LO: begin
        // Leaving SCLK_LO is the edge where adc_sclk rises: sample the data bit here
        if (div_last) begin
          state_d   = SCLK_HI;
          div_cnt_d = '0;
          shreg_d   = {shreg_q[FRAME_W-2:0], bus.adc_sdata};
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + DIV_W'(1));
        end
      end
      SCLK_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          bit_cnt_d = BIT_W'(bit_cnt_q + BIT_W'(1));
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
            state_d = DONE;
            if (shreg_q[FRAME_W-1:DATA_W] == '0) begin
              dout_d  = conv;
              valid_d = 1'b1;
            end else begin
              err_d   = 1'b1;
            end
          end else begin
            state_d = SCLK_LO;
          end
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + DIV_W'(1));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_n_d = (state_d == IDLE) || (state_d == DONE);
    sclk_d = (state_d != SCLK_LO);
    busy_d = (state_d != IDLE);
  end

  assign bus.adc_cs_n   = cs_n_q;
  assign bus.adc_sclk   = sclk_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: frame timing, code conversion table,
// bad frames, en drop, mid-frame reset, and a minimum-period two's-complement instance.
module tb_adc_serial_capture;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  adc_serial_capture_if bus ();
  adc_serial_capture_if bus2 ();

  adc_serial_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adc_serial_capture #(
    .CLK_DIV       (1),
    .SAMPLE_PERIOD (35),
    .OFFSET_BINARY (1'b0)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  // ADC models: present frame bit 15-bitpos, advance after each observed sclk rise
  logic [15:0] frame_word  = 16'h0800;
  logic [15:0] frame_word2 = 16'h0FFF;
  int   bitpos  = 0;
  int   bitpos2 = 0;
  logic sclk_prev  = 1'b1;
  logic sclk_prev2 = 1'b1;

  always @(posedge clk) begin
    if (bus.adc_cs_n) bitpos <= 0;
    else if (bus.adc_sclk && !sclk_prev) bitpos <= bitpos + 1;
    sclk_prev <= bus.adc_sclk;
  end

  always @(posedge clk) begin
    if (bus2.adc_cs_n) bitpos2 <= 0;
    else if (bus2.adc_sclk && !sclk_prev2) bitpos2 <= bitpos2 + 1;
    sclk_prev2 <= bus2.adc_sclk;
  end

  always_comb bus.adc_sdata  = (bitpos  < 16) ? frame_word[4'(15 - bitpos)]   : 1'b0;
  always_comb bus2.adc_sdata = (bitpos2 < 16) ? frame_word2[4'(15 - bitpos2)] : 1'b0;

  // Strobe exclusivity / no back-to-back strobes on the main instance
  int   strobe_viol = 0;
  logic pv = 1'b0, pe = 1'b0;
  always @(posedge clk) begin
    if ((bus.dout_valid && bus.frame_err) ||
        ((bus.dout_valid || bus.frame_err) && (pv || pe)))
      strobe_viol <= strobe_viol + 1;
    pv <= bus.dout_valid;
    pe <= bus.frame_err;
  end

  // Second instance: every frame must give -1 exactly 35 cycles apart
  int cyc = 0;
  int last_v2 = -1;
  int n_v2 = 0;
  int d2_bad = 0;
  int per2_bad = 0;
  int err2 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus2.frame_err) err2 <= err2 + 1;
    if (bus2.dout_valid) begin
      n_v2 <= n_v2 + 1;
      if (bus2.dout !== 12'hFFF) d2_bad <= d2_bad + 1;
      if (last_v2 >= 0 && (cyc - last_v2) != 35) per2_bad <= per2_bad + 1;
      last_v2 <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.dout_valid || bus.frame_err) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs_fall(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!bus.adc_cs_n) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    bit          is_err;
    logic [11:0] dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit   got;
    int   sclk_bad, cs_bad, rises, first_valid, first_cs, nstrobe, lows;
    logic exp_s, exp_cs, prev_s;
    logic [11:0] valid_dout;

    vecs[0] = '{16'h0FFF, 1'b0, 12'h7FF};
    vecs[1] = '{16'h0000, 1'b0, 12'h800};
    vecs[2] = '{16'h0801, 1'b0, 12'h001};
    vecs[3] = '{16'h1ABC, 1'b1, 12'h001};
    vecs[4] = '{16'h0ABC, 1'b0, 12'h2BC};
    vecs[5] = '{16'h8000, 1'b1, 12'h2BC};
    vecs[6] = '{16'h07FF, 1'b0, 12'hFFF};
    vecs[7] = '{16'h0123, 1'b0, 12'h923};

    rst = 1'b1; rst2 = 1'b1;
    bus.en = 1'b0; bus2.en = 1'b0;
    repeat (3) step();
    check("rst_cs_n",  32'(bus.adc_cs_n),   32'd1);
    check("rst_sclk",  32'(bus.adc_sclk),   32'd1);
    check("rst_dout",  32'(bus.dout),       32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_err",   32'(bus.frame_err),  32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);

    rst = 1'b0; rst2 = 1'b0;
    bus2.en = 1'b1;
    step();
    check("idle_en0_cs_n", 32'(bus.adc_cs_n), 32'd1);
    check("idle_en0_busy", 32'(bus.busy),     32'd0);

    // Frame timing at default parameters, raw 0x800
    bus.en = 1'b1;
    step();
    check("start_cs_fall", 32'(bus.adc_cs_n), 32'd0);
    check("start_busy",    32'(bus.busy),     32'd1);
    sclk_bad = 0; cs_bad = 0; rises = 0; first_valid = -1; first_cs = -1; nstrobe = 0;
    prev_s = bus.adc_sclk;
    valid_dout = 12'hABC;
    for (int k = 1; k <= 100; k++) begin
      step();
      exp_s  = (k >= 2 && k <= 65) ? (((k - 2) % 4) >= 2) : 1'b1;
      exp_cs = (k >= 66 && k <= 99);
      if (bus.adc_sclk !== exp_s) sclk_bad++;
      if (bus.adc_cs_n !== exp_cs) cs_bad++;
      if (bus.adc_sclk && !prev_s) rises++;
      prev_s = bus.adc_sclk;
      if (bus.dout_valid && first_valid < 0) begin
        first_valid = k;
        valid_dout  = bus.dout;
      end
      if (bus.dout_valid || bus.frame_err) nstrobe++;
      if (!bus.adc_cs_n && k > 66 && first_cs < 0) first_cs = k;
    end
    check("sclk_pattern_bad_cycles", 32'(sclk_bad),    32'd0);
    check("cs_pattern_bad_cycles",   32'(cs_bad),      32'd0);
    check("sclk_rises",              32'(rises),       32'd16);
    check("valid_at_T67",            32'(first_valid), 32'd66);
    check("dout_raw800",             32'(valid_dout),  32'd0);
    check("one_strobe_per_frame",    32'(nstrobe),     32'd1);
    check("next_start_T100",         32'(first_cs),    32'd100);

    // Conversion and frame-check table
    foreach (vecs[i]) begin
      frame_word = vecs[i].word;
      wait_strobe(150, got);
      check($sformatf("vec%0d_strobe_seen", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_valid", i), 32'(bus.dout_valid), 32'(!vecs[i].is_err));
      check($sformatf("vec%0d_err", i),   32'(bus.frame_err),  32'(vecs[i].is_err));
      check($sformatf("vec%0d_dout", i),  32'(bus.dout),       32'(vecs[i].dout));
      step();
      check($sformatf("vec%0d_strobe_1cyc", i), 32'(bus.dout_valid | bus.frame_err), 32'd0);
    end

    // en dropped mid-frame at T+20: frame completes, then silence
    frame_word = 16'h0456;
    wait_cs_fall(120, got);
    check("endrop_start_seen", 32'(got), 32'd1);
    first_valid = -1;
    valid_dout  = 12'h000;
    for (int k = 1; k <= 66; k++) begin
      step();
      if (k == 19) bus.en = 1'b0;
      if (bus.dout_valid && first_valid < 0) begin
        first_valid = k;
        valid_dout  = bus.dout;
      end
    end
    check("endrop_valid_T67", 32'(first_valid), 32'd66);
    check("endrop_dout",      32'(valid_dout),  32'h0C56);
    lows = 0; nstrobe = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!bus.adc_cs_n) lows++;
      if (bus.dout_valid || bus.frame_err) nstrobe++;
    end
    check("endrop_cs_quiet",     32'(lows),     32'd0);
    check("endrop_no_strobe",    32'(nstrobe),  32'd0);
    check("endrop_idle_busy",    32'(bus.busy), 32'd0);
    check("endrop_dout_held",    32'(bus.dout), 32'h0C56);

    // en returns: immediate start; reset pulse at T+30 aborts the frame
    frame_word = 16'h0F00;
    bus.en = 1'b1;
    step();
    check("enret_cs_fall", 32'(bus.adc_cs_n), 32'd0);
    nstrobe = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (bus.dout_valid || bus.frame_err) nstrobe++;
    end
    rst = 1'b1;
    step();
    check("midrst_cs_n",   32'(bus.adc_cs_n),   32'd1);
    check("midrst_sclk",   32'(bus.adc_sclk),   32'd1);
    check("midrst_dout",   32'(bus.dout),       32'd0);
    check("midrst_busy",   32'(bus.busy),       32'd0);
    if (bus.dout_valid || bus.frame_err) nstrobe++;
    check("midrst_no_strobe", 32'(nstrobe), 32'd0);
    rst = 1'b0;
    step();
    check("postrst_start", 32'(bus.adc_cs_n), 32'd0);
    first_valid = -1;
    valid_dout  = 12'h000;
    for (int k = 1; k <= 66; k++) begin
      step();
      if (bus.dout_valid && first_valid < 0) begin
        first_valid = k;
        valid_dout  = bus.dout;
      end
    end
    check("postrst_valid_T67", 32'(first_valid), 32'd66);
    check("postrst_dout",      32'(valid_dout),  32'h0700);

    repeat (5) step();
    check("strobe_rule_violations", 32'(strobe_viol), 32'd0);
    check("twos_frames_seen",       32'(n_v2 >= 10),  32'd1);
    check("twos_dout_bad",          32'(d2_bad),      32'd0);
    check("twos_period_bad",        32'(per2_bad),    32'd0);
    check("twos_frame_err",         32'(err2),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
